mem_access_unit: RTL and testbench

Memory-stage access controller sitting directly downstream of the EX/MEM pipeline register. It turns the registered load/store controls into a single-outstanding request/acknowledge transaction on the data bus, stalls the pipeline until the access completes, and returns sign- or zero-extended load data to the MEM/WB path. It also flags misaligned addresses and bus timeouts for the CP0 exception logic.

---
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: turns EX/MEM load/store controls into a single
// outstanding req/ack bus transaction, stalls the pipeline and extends load data.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exmem_mem_r,
    input  logic        exmem_mem_w,
    input  logic [31:0] exmem_alu_res,
    input  logic [31:0] exmem_rt_data,
    input  logic [3:0]  mem_byte_w_en,
    input  logic [2:0]  exmem_load_sel,
    input  logic [2:0]  exmem_store_sel,
    input  logic        exmem_hold,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        addr_err_l,
    output logic        addr_err_s,
    output logic        bus_err
);

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;
    localparam logic [2:0] ST_SB  = 3'd1;
    localparam logic [2:0] ST_SH  = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       lsel_q, lsel_nxt;
    logic [1:0]       off_q, off_nxt;
    logic             bus_req_nxt, bus_we_nxt, bus_err_nxt;
    logic [31:0]      bus_addr_nxt, bus_wdata_nxt, load_data_nxt;
    logic [3:0]       bus_be_nxt;

    logic             ld_mis, st_mis, access, aligned_access;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      rd_ext;

    // Alignment decode; a store wins when both controls are set.
    always_comb begin
        ld_mis = |exmem_alu_res[1:0];
        st_mis = |exmem_alu_res[1:0];
        case (exmem_load_sel)
            LD_LB, LD_LBU: ld_mis = 1'b0;
            LD_LH, LD_LHU: ld_mis = exmem_alu_res[0];
            default:       ld_mis = |exmem_alu_res[1:0];
        endcase
        case (exmem_store_sel)
            ST_SB:   st_mis = 1'b0;
            ST_SH:   st_mis = exmem_alu_res[0];
            default: st_mis = |exmem_alu_res[1:0];
        endcase
    end

    assign access         = exmem_mem_r | exmem_mem_w;
    assign addr_err_s     = exmem_mem_w & st_mis;
    assign addr_err_l     = exmem_mem_r & ~exmem_mem_w & ld_mis;
    assign aligned_access = access & ~(exmem_mem_w ? st_mis : ld_mis);
    assign mem_stall      = ((state == IDLE) & aligned_access) | (state == REQ);

    // Little-endian lane select and extension from the latched access info.
    always_comb begin
        rd_byte = bus_rdata[{off_q, 3'b000} +: 8];
        rd_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (lsel_q)
            LD_LB:   rd_ext = {{24{rd_byte[7]}}, rd_byte};
            LD_LBU:  rd_ext = {24'h000000, rd_byte};
            LD_LH:   rd_ext = {{16{rd_half[15]}}, rd_half};
            LD_LHU:  rd_ext = {16'h0000, rd_half};
            default: rd_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        lsel_nxt      = lsel_q;
        off_nxt       = off_q;
        bus_req_nxt   = 1'b0;
        bus_we_nxt    = bus_we;
        bus_addr_nxt  = bus_addr;
        bus_wdata_nxt = bus_wdata;
        bus_be_nxt    = bus_be;
        load_data_nxt = load_data;
        bus_err_nxt   = bus_err;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (aligned_access) begin
                    bus_we_nxt    = exmem_mem_w;
                    bus_addr_nxt  = {exmem_alu_res[31:2], 2'b00};
                    bus_wdata_nxt = exmem_rt_data;
                    bus_be_nxt    = exmem_mem_w ? mem_byte_w_en : 4'hF;
                    lsel_nxt      = exmem_load_sel;
                    off_nxt       = exmem_alu_res[1:0];
                    bus_err_nxt   = 1'b0;
                    bus_req_nxt   = 1'b1;
                    state_nxt     = REQ;
                end
            end
            REQ: begin
                // Ack takes precedence over a timeout landing in the same cycle.
                if (bus_ack) begin
                    if (!bus_we) begin
                        load_data_nxt = rd_ext;
                    end
                    state_nxt = DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    bus_err_nxt   = 1'b1;
                    load_data_nxt = '0;
                    state_nxt     = DONE;
                end else begin
                    cnt_nxt     = cnt + CNT_W'(1);
                    bus_req_nxt = 1'b1;
                end
            end
            DONE: begin
                if (!exmem_hold) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lsel_q    <= '0;
            off_q     <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            load_data <= '0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lsel_q    <= lsel_nxt;
            off_q     <= off_nxt;
            bus_req   <= bus_req_nxt;
            bus_we    <= bus_we_nxt;
            bus_addr  <= bus_addr_nxt;
            bus_wdata <= bus_wdata_nxt;
            bus_be    <= bus_be_nxt;
            load_data <= load_data_nxt;
            bus_err   <= bus_err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expected transactions,
// monitor pops and compares as each bus transaction or address error appears.
module tb_mem_access_unit;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 8;
    localparam logic [31:0] JUNK    = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        exmem_mem_r, exmem_mem_w, exmem_hold;
    logic [31:0] exmem_alu_res, exmem_rt_data;
    logic [3:0]  mem_byte_w_en;
    logic [2:0]  exmem_load_sel, exmem_store_sel;
    logic        bus_req, bus_we, bus_ack, mem_stall, addr_err_l, addr_err_s, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata, load_data;
    logic [3:0]  bus_be;

    mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .exmem_mem_r(exmem_mem_r), .exmem_mem_w(exmem_mem_w),
        .exmem_alu_res(exmem_alu_res), .exmem_rt_data(exmem_rt_data),
        .mem_byte_w_en(mem_byte_w_en), .exmem_load_sel(exmem_load_sel),
        .exmem_store_sel(exmem_store_sel), .exmem_hold(exmem_hold),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .mem_stall(mem_stall), .load_data(load_data),
        .addr_err_l(addr_err_l), .addr_err_s(addr_err_s), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          misal;
        bit          err_l;
        bit          err_s;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          req_cycles;
        logic [31:0] load_data;
        bit          bus_err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: samples 1 time unit before each rising edge.
    bit          in_txn = 1'b0;
    bit          stable = 1'b1;
    int          req_n = 0;
    int          stall_run = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (!reset) begin
                in_txn = 1'b0; req_n = 0; stall_run = 0;
            end else begin
                if (addr_err_l || addr_err_s) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_addr_err: got l=%0b s=%0b required none", addr_err_l, addr_err_s);
                    end else begin
                        e = exp_q.pop_front();
                        check("addr_err_l", 32'(addr_err_l), 32'(e.err_l));
                        check("addr_err_s", 32'(addr_err_s), 32'(e.err_s));
                        check("misal_no_req", 32'(bus_req), 32'(0));
                        check("misal_no_stall", 32'(mem_stall), 32'(0));
                    end
                end
                if (bus_req) begin
                    if (!in_txn) begin
                        in_txn = 1'b1; req_n = 0; stable = 1'b1;
                        cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be; cap_we = bus_we;
                    end else if (bus_addr !== cap_addr || bus_wdata !== cap_wdata ||
                                 bus_be !== cap_be || bus_we !== cap_we) begin
                        stable = 1'b0;
                    end
                    req_n++;
                end else if (in_txn) begin
                    in_txn = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_txn: got addr 0x%08h required none", cap_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("txn_kind", 32'(e.misal), 32'(0));
                        check("bus_we", 32'(cap_we), 32'(e.we));
                        check("bus_addr", cap_addr, e.addr);
                        check("bus_wdata", cap_wdata, e.wdata);
                        check("bus_be", 32'(cap_be), 32'(e.be));
                        check("req_cycles", 32'(req_n), 32'(e.req_cycles));
                        check("bus_stable", 32'(stable), 32'(1));
                        check("load_data", load_data, e.load_data);
                        check("bus_err", 32'(bus_err), 32'(e.bus_err));
                        check("stall_cycles", 32'(stall_run), 32'(e.req_cycles + 1));
                        check("done_no_stall", 32'(mem_stall), 32'(0));
                    end
                end
                stall_run = mem_stall ? stall_run + 1 : 0;
            end
        end
    end

    // Driver + bus responder; called at negedge+1. waits < 0 means never ack.
    task automatic do_access(input bit r, input bit w, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] be,
                             input logic [2:0] lsel, input logic [2:0] ssel,
                             input int waits, input logic [31:0] rdata, input int hold_n,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_ld, input bit exp_err);
        exp_t e;
        int   n;
        int   guard;
        e.misal = 1'b0; e.err_l = 1'b0; e.err_s = 1'b0;
        e.we = w; e.addr = exp_addr; e.wdata = wd; e.be = exp_be;
        e.req_cycles = (waits < 0) ? int'(TIMEOUT) : waits + 1;
        e.load_data = exp_ld; e.bus_err = exp_err;
        exp_q.push_back(e);
        exmem_mem_r = r; exmem_mem_w = w; exmem_alu_res = addr; exmem_rt_data = wd;
        mem_byte_w_en = be; exmem_load_sel = lsel; exmem_store_sel = ssel;
        n = 0; guard = 0;
        do begin
            @(negedge clk);
            #1;
            bus_ack = 1'b0; bus_rdata = JUNK;
            if (bus_req) begin
                n++;
                if (waits >= 0 && n == waits + 1) begin
                    bus_ack = 1'b1; bus_rdata = rdata;
                end
            end
            guard++;
        end while (!(n > 0 && !bus_req) && guard < 40);
        if (guard >= 40) begin
            n_cmp++; n_bad++;
            $display("FAIL txn_timeout: got no completion after %0d cycles required completion", guard);
        end
        if (hold_n > 0) begin
            exmem_hold = 1'b1;
            repeat (hold_n) begin
                @(negedge clk);
                #1;
                check("hold_no_req", 32'(bus_req), 32'(0));
                check("hold_no_stall", 32'(mem_stall), 32'(0));
            end
        end
        exmem_hold = 1'b0; exmem_mem_r = 1'b0; exmem_mem_w = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic do_misal(input bit r, input bit w, input logic [31:0] addr,
                            input logic [2:0] lsel, input logic [2:0] ssel,
                            input bit exp_l, input bit exp_s);
        exp_t e;
        e.misal = 1'b1; e.err_l = exp_l; e.err_s = exp_s;
        e.we = 1'b0; e.addr = '0; e.wdata = '0; e.be = '0;
        e.req_cycles = 0; e.load_data = '0; e.bus_err = 1'b0;
        exp_q.push_back(e);
        exmem_mem_r = r; exmem_mem_w = w; exmem_alu_res = addr;
        exmem_load_sel = lsel; exmem_store_sel = ssel; mem_byte_w_en = 4'h3;
        @(negedge clk);
        #1;
        exmem_mem_r = 1'b0; exmem_mem_w = 1'b0;
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        exmem_mem_r = 1'b0; exmem_mem_w = 1'b0; exmem_hold = 1'b0;
        exmem_alu_res = '0; exmem_rt_data = '0; mem_byte_w_en = '0;
        exmem_load_sel = '0; exmem_store_sel = '0;
        bus_ack = 1'b0; bus_rdata = JUNK;
        #3;
        check("rst_bus_req", 32'(bus_req), 32'(0));
        check("rst_bus_we", 32'(bus_we), 32'(0));
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_be", 32'(bus_be), 32'(0));
        check("rst_load_data", load_data, 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'(0));
        check("rst_mem_stall", 32'(mem_stall), 32'(0));
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        #1;

        // r  w  addr          wdata         be    lsel  ssel waits rdata         hold exp_addr      exp_be exp_ld        err
        do_access(1, 0, 32'h100, 32'h0, 4'h0, 3'd0, 3'd0, 0, 32'hDEADBEEF, 0, 32'h100, 4'hF, 32'hDEADBEEF, 0);
        do_access(1, 0, 32'h103, 32'h0, 4'h0, 3'd1, 3'd0, 3, 32'h80FF7F01, 0, 32'h100, 4'hF, 32'hFFFFFF80, 0);
        do_access(1, 0, 32'h103, 32'h0, 4'h0, 3'd2, 3'd0, 3, 32'h80FF7F01, 0, 32'h100, 4'hF, 32'h00000080, 0);
        do_access(1, 0, 32'h102, 32'h0, 4'h0, 3'd3, 3'd0, 3, 32'h80FF7F01, 0, 32'h100, 4'hF, 32'hFFFF80FF, 0);
        do_access(1, 0, 32'h100, 32'h0, 4'h0, 3'd4, 3'd0, 3, 32'h80FF7F01, 0, 32'h100, 4'hF, 32'h00007F01, 0);
        do_access(1, 0, 32'h101, 32'h0, 4'h0, 3'd1, 3'd0, 1, 32'h80FF7F01, 0, 32'h100, 4'hF, 32'h0000007F, 0);
        do_access(0, 1, 32'h201, 32'h0000AB00, 4'h2, 3'd0, 3'd1, 0, 32'h11111111, 0, 32'h200, 4'h2, 32'h0000007F, 0);

        do_misal(1, 0, 32'h102, 3'd0, 3'd0, 1, 0);
        do_misal(0, 1, 32'h301, 3'd0, 3'd2, 0, 1);

        do_access(1, 0, 32'h300, 32'h0, 4'h0, 3'd0, 3'd0, -1, 32'h0, 3, 32'h300, 4'hF, 32'h0, 1);
        do_access(0, 1, 32'h304, 32'hCAFEF00D, 4'hF, 3'd0, 3'd0, 2, 32'h0, 0, 32'h304, 4'hF, 32'h0, 0);

        // Reset while the bus request is outstanding.
        exmem_mem_r = 1'b1; exmem_alu_res = 32'h400; exmem_rt_data = 32'h55AA55AA; exmem_load_sel = 3'd0;
        repeat (2) @(negedge clk);
        #1;
        check("pre_rst_req", 32'(bus_req), 32'(1));
        #1;
        reset = 1'b0; exmem_mem_r = 1'b0;
        #1;
        check("mid_rst_bus_req", 32'(bus_req), 32'(0));
        check("mid_rst_bus_addr", bus_addr, 32'h0);
        check("mid_rst_bus_wdata", bus_wdata, 32'h0);
        check("mid_rst_bus_be", 32'(bus_be), 32'(0));
        check("mid_rst_mem_stall", 32'(mem_stall), 32'(0));
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        do_access(1, 0, 32'h104, 32'h0, 4'h0, 3'd0, 3'd0, 1, 32'h01234567, 0, 32'h104, 4'hF, 32'h01234567, 0);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
